sram_bank_access_ctrl: RTL and testbench

Request-side controller for a single 256 x 64-bit SRAM bank wrapper (4 words x 16 bits per line, active-high chip/write enables, one-cycle read latency). Accepts independent write and read request streams over valid/ready, arbitrates one bank access per cycle, and drives the bank pins. Returns read data in request order through a 2-entry output buffer with valid/ready backpressure, so no read data is ever dropped. Sits between the address generators or streaming logic and the bank wrapper.

---
 rtl/sram_bank_access_ctrl.sv | 115 +++++++++++
 tb/tb_sram_bank_access_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_access_ctrl.sv
// Request-side controller for one SRAM bank: arbitrates write/read requests onto the
// bank pins and returns read lines in order through a 2-entry output buffer.
module sram_bank_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int FW     = 4,
  parameter int DW     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [FW-1:0][DW-1:0]     wr_data,
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_data_valid,
  input  logic                      rd_data_ready,
  output logic [FW-1:0][DW-1:0]     rd_data,
  output logic [ADDR_W-1:0]         mem_addr_in_bank,
  output logic                      mem_cen_in_bank,
  output logic                      mem_wen_in_bank,
  output logic [FW-1:0][DW-1:0]     mem_data_in_bank,
  input  logic [FW-1:0][DW-1:0]     mem_data_out_bank
);

  typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_e;

  grant_e                 last_grant_reg;
  logic [1:0]             occ_reg;
  logic [1:0]             occ_next;
  logic                   inflight_reg;
  logic                   head_reg;
  logic                   tail_reg;
  logic [FW-1:0][DW-1:0]  line_buf [2];

  logic       active;
  logic       pop;
  logic [2:0] pending;
  logic       read_eligible;
  logic       rd_req;
  logic       contention;
  logic       grant_wr;
  logic       grant_rd;

  assign active        = clk_en & ~reset;
  assign rd_data_valid = active & (occ_reg != 2'd0);
  assign pop           = rd_data_valid & rd_data_ready;

  // Slots already claimed: buffered lines plus a read still in the bank pipeline.
  assign pending       = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign read_eligible = (pending - {2'b00, pop}) <= 3'd1;

  assign rd_req     = rd_valid & read_eligible;
  assign contention = wr_valid & rd_req;
  assign grant_wr   = active & wr_valid & (~rd_req | (last_grant_reg == GRANT_RD));
  assign grant_rd   = active & rd_req & (~wr_valid | (last_grant_reg == GRANT_WR));

  assign wr_ready = grant_wr;
  assign rd_ready = grant_rd;
  assign rd_data  = reset ? '0 : line_buf[head_reg];

  always_comb begin
    mem_cen_in_bank  = 1'b0;
    mem_wen_in_bank  = 1'b0;
    mem_addr_in_bank = '0;
    mem_data_in_bank = '0;
    if (grant_wr) begin
      mem_cen_in_bank  = 1'b1;
      mem_wen_in_bank  = 1'b1;
      mem_addr_in_bank = wr_addr;
      mem_data_in_bank = wr_data;
    end else if (grant_rd) begin
      mem_cen_in_bank  = 1'b1;
      mem_addr_in_bank = rd_addr;
    end
  end

  assign occ_next = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_reg        <= 2'd0;
      inflight_reg   <= 1'b0;
      head_reg       <= 1'b0;
      tail_reg       <= 1'b0;
      last_grant_reg <= GRANT_RD;
    end else if (clk_en) begin
      occ_reg      <= occ_next;
      inflight_reg <= grant_rd;
      if (inflight_reg) begin
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      if (contention) begin
        last_grant_reg <= grant_wr ? GRANT_WR : GRANT_RD;
      end
    end
  end

  // Bank Q holds while idle, so a capture delayed by clk_en low still sees the right line.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line_buf
      always_ff @(posedge clk) begin
        if (~reset && clk_en && inflight_reg && (tail_reg == 1'(gi))) begin
          line_buf[gi] <= mem_data_out_bank;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_bank_access_ctrl.sv
// Bench for sram_bank_access_ctrl: vector table, directed corner sequences and a
// randomized run against a queue-based reference model with a behavioural bank.
module tb_sram_bank_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_addr = 8'h00;
  logic [63:0] wr_data = 64'h0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [7:0]  rd_addr = 8'h00;
  logic        rd_data_valid;
  logic        rd_data_ready = 1'b0;
  logic [63:0] rd_data;
  logic [7:0]  mem_addr_in_bank;
  logic        mem_cen_in_bank;
  logic        mem_wen_in_bank;
  logic [63:0] mem_data_in_bank;
  logic [63:0] mem_data_out_bank;

  always #5 clk = ~clk;

  sram_bank_access_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .clk_en            (clk_en),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_addr           (rd_addr),
    .rd_data_valid     (rd_data_valid),
    .rd_data_ready     (rd_data_ready),
    .rd_data           (rd_data),
    .mem_addr_in_bank  (mem_addr_in_bank),
    .mem_cen_in_bank   (mem_cen_in_bank),
    .mem_wen_in_bank   (mem_wen_in_bank),
    .mem_data_in_bank  (mem_data_in_bank),
    .mem_data_out_bank (mem_data_out_bank)
  );

  // Behavioural bank: one-cycle read latency, Q holds when not read.
  logic [63:0] bank [256];
  always @(posedge clk) begin
    if (mem_cen_in_bank) begin
      if (mem_wen_in_bank) bank[mem_addr_in_bank] <= mem_data_in_bank;
      else                 mem_data_out_bank <= bank[mem_addr_in_bank];
    end
  end

  // Reference model: shadow memory plus queue of accepted, not yet delivered reads.
  typedef struct {
    logic [63:0] data;
    int          g;
  } resp_t;
  resp_t       exp_q[$];
  logic [63:0] ref_mem [256];
  int          ecnt = 0;
  bit          last_rd = 1'b1;

  int total = 0;
  int bad = 0;

  logic s_wr, s_rd, s_cen, s_wen, s_dv;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step(input bit rst_i, input bit ce_i, input bit wv_i, input bit rv_i,
                      input bit rdy_i, input logic [7:0] wa, input logic [63:0] wd,
                      input logic [7:0] ra);
    bit    act, ev, pop, elig, ewr, erd;
    resp_t r;
    @(negedge clk);
    reset = rst_i; clk_en = ce_i; wr_valid = wv_i; rd_valid = rv_i;
    rd_data_ready = rdy_i; wr_addr = wa; wr_data = wd; rd_addr = ra;
    #1;
    act  = ce_i && !rst_i;
    ev   = act && (exp_q.size() > 0) && ((ecnt - exp_q[0].g) >= 2);
    pop  = ev && rdy_i;
    elig = (exp_q.size() - int'(pop)) <= 1;
    ewr  = act && wv_i && (!(rv_i && elig) || last_rd);
    erd  = act && rv_i && elig && (!wv_i || !last_rd);
    s_wr = wr_ready; s_rd = rd_ready; s_cen = mem_cen_in_bank;
    s_wen = mem_wen_in_bank; s_dv = rd_data_valid;
    chk("wr_ready", 64'(wr_ready), 64'(ewr));
    chk("rd_ready", 64'(rd_ready), 64'(erd));
    chk("rd_data_valid", 64'(rd_data_valid), 64'(ev));
    if (ev) chk("rd_data", rd_data, exp_q[0].data);
    if (rst_i) chk("rd_data_in_reset", rd_data, 64'h0);
    chk("mem_cen", 64'(mem_cen_in_bank), 64'(ewr || erd));
    chk("mem_wen", 64'(mem_wen_in_bank), 64'(ewr));
    chk("mem_addr", 64'(mem_addr_in_bank), ewr ? 64'(wa) : (erd ? 64'(ra) : 64'h0));
    chk("mem_data", mem_data_in_bank, ewr ? wd : 64'h0);
    if (rst_i) begin
      exp_q.delete();
      last_rd = 1'b1;
    end else if (act) begin
      if (pop) void'(exp_q.pop_front());
      if (ewr) ref_mem[wa] = wd;
      if (erd) begin
        r.data = ref_mem[ra];
        r.g    = ecnt;
        exp_q.push_back(r);
      end
      if (wv_i && rv_i && elig) last_rd = erd;
      ecnt++;
    end
  endtask

  task automatic idle_drain(output int n);
    n = 0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      step(0, 1, 0, 0, 1, 8'h00, 64'h0, 8'h00);
      n += int'(s_dv);
    end
    chk("drain_empty", 64'(exp_q.size()), 64'h0);
  endtask

  typedef struct {
    bit rst, ce, wv, rv, rdy;
    bit e_wr, e_rd, e_cen, e_wen, e_dv;
  } vec_t;
  vec_t vecs[12];

  localparam logic [63:0] LINE5 = 64'h4444_3333_2222_1111;

  initial begin
    int n;
    int acc;
    vecs[0]  = '{1,1,1,1,1, 0,0,0,0,0};
    vecs[1]  = '{0,1,1,0,1, 1,0,1,1,0};
    vecs[2]  = '{0,1,0,1,1, 0,1,1,0,0};
    vecs[3]  = '{0,1,0,0,1, 0,0,0,0,0};
    vecs[4]  = '{0,1,0,0,1, 0,0,0,0,1};
    vecs[5]  = '{0,1,1,1,1, 1,0,1,1,0};
    vecs[6]  = '{0,1,1,1,1, 0,1,1,0,0};
    vecs[7]  = '{0,1,1,1,1, 1,0,1,1,0};
    vecs[8]  = '{0,1,1,1,1, 0,1,1,0,1};
    vecs[9]  = '{0,0,1,1,1, 0,0,0,0,0};
    vecs[10] = '{0,1,0,0,1, 0,0,0,0,0};
    vecs[11] = '{0,1,0,0,1, 0,0,0,0,1};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].ce, vecs[i].wv, vecs[i].rv, vecs[i].rdy, 8'h05, LINE5, 8'h05);
      chk($sformatf("vec%0d_wr_ready", i), 64'(s_wr), 64'(vecs[i].e_wr));
      chk($sformatf("vec%0d_rd_ready", i), 64'(s_rd), 64'(vecs[i].e_rd));
      chk($sformatf("vec%0d_cen", i), 64'(s_cen), 64'(vecs[i].e_cen));
      chk($sformatf("vec%0d_wen", i), 64'(s_wen), 64'(vecs[i].e_wen));
      chk($sformatf("vec%0d_dv", i), 64'(s_dv), 64'(vecs[i].e_dv));
      if (i == 4) chk("vec4_line", rd_data, LINE5);
      $display("vec %0d: wr_ready=%0d rd_ready=%0d cen=%0d wen=%0d dv=%0d",
               i, s_wr, s_rd, s_cen, s_wen, s_dv);
    end

    // Preload every line so all later reads have known contents.
    for (int a = 0; a < 256; a++) begin
      step(0, 1, 1, 0, 1, 8'(a), {$urandom, $urandom}, 8'h00);
    end
    idle_drain(n);

    // Streaming reads, one response per cycle.
    n = 0;
    for (int a = 0; a < 16; a++) begin
      step(0, 1, 0, 1, 1, 8'h00, 64'h0, 8'(a));
      chk("stream_rd_ready", 64'(s_rd), 64'h1);
      n += int'(s_dv);
    end
    chk("stream_dv_in_flight", 64'(n), 64'd14);
    idle_drain(acc);
    chk("stream_resp_count", 64'(n + acc), 64'd16);
    $display("stream: %0d responses", n + acc);

    // Backpressure: only two reads fit, writes still go through.
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 1, 0, 8'h00, 64'h0, 8'(8'h20 + k));
      acc += int'(s_rd);
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 1, 1, 0, 8'(8'h30 + k), {$urandom, $urandom}, 8'h26);
      chk("bp_wr_granted", 64'(s_wr), 64'h1);
      chk("bp_rd_blocked", 64'(s_rd), 64'h0);
    end
    idle_drain(n);
    chk("bp_drained", 64'(n), 64'd2);
    step(0, 1, 0, 1, 1, 8'h00, 64'h0, 8'h31);
    chk("bp_resume", 64'(s_rd), 64'h1);
    idle_drain(n);
    $display("backpressure: accepted=%0d", acc);

    // clk_en low for three cycles right after a read grant.
    step(0, 1, 0, 1, 1, 8'h00, 64'h0, 8'h05);
    chk("ce_read_grant", 64'(s_rd), 64'h1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 1, 8'h40, 64'h1234, 8'h06);
      chk("ce_no_grant", 64'({s_wr, s_rd, s_dv}), 64'h0);
    end
    idle_drain(n);
    chk("ce_delivered", 64'(n), 64'd1);
    $display("clk_en gap: delivered=%0d", n);

    // Reset with one line buffered and one read in flight.
    step(0, 1, 0, 1, 0, 8'h00, 64'h0, 8'h07);
    step(0, 1, 0, 1, 0, 8'h00, 64'h0, 8'h08);
    chk("rst_pre_second_read", 64'(s_rd), 64'h1);
    step(1, 1, 0, 0, 0, 8'h00, 64'h0, 8'h00);
    step(0, 1, 0, 0, 1, 8'h00, 64'h0, 8'h00);
    chk("rst_dv_cleared", 64'(s_dv), 64'h0);
    chk("rst_cen_cleared", 64'(s_cen), 64'h0);
    step(0, 1, 0, 1, 1, 8'h00, 64'h0, 8'h09);
    idle_drain(n);
    chk("rst_only_own_data", 64'(n), 64'd1);
    $display("reset mid-op: post-reset responses=%0d", n);

    // Randomized traffic on a small address range to force collisions.
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom_range(0, 15)));
    end
    step(0, 1, 0, 0, 1, 8'h00, 64'h0, 8'h00);
    step(0, 1, 0, 0, 1, 8'h00, 64'h0, 8'h00);
    idle_drain(n);
    $display("random: done, %0d checks so far", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
